// File: rtl/store_buffer.sv
// FIFO store buffer between EX/MEM and data_memory, draining when loads leave the port free
// and forwarding the youngest matching store to loads. Define STORE_BUF_COALESCE_EN to coalesce.
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   input  logic [AW-1:0]            st_addr,
   input  logic [DW-1:0]            st_data,
   output logic                     st_ready,
   input  logic                     ld_valid,
   input  logic [AW-1:0]            ld_addr,
   output logic                     ld_hit,
   output logic [DW-1:0]            ld_data,
   output logic                     mem_write,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} occ_e;

   occ_e             state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] vld_q;

   logic full, drain, co_hit, enq;

   assign full  = (state_q == S_FULL);
   assign empty = (state_q == S_EMPTY);
   assign drain = !empty && !ld_valid;
   assign count = count_q;

`ifdef STORE_BUF_COALESCE_EN
   logic [PW-1:0] yng_idx;
   assign yng_idx = wr_ptr_q - PW'(1);
   // Youngest entry may absorb the store unless it is leaving for memory this cycle.
   assign co_hit  = !empty && (addr_q[yng_idx] == st_addr) && !(drain && (yng_idx == rd_ptr_q));
`else
   assign co_hit  = 1'b0;
`endif

   assign st_ready = !full || co_hit;
   assign enq      = st_valid && st_ready && !co_hit;

   always_comb begin : ctrl
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      mem_write = drain;
      mem_addr  = ld_addr;
      mem_wdata = '0;
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (drain) begin
         rd_ptr_d  = rd_ptr_q + PW'(1);
         mem_addr  = addr_q[rd_ptr_q];
         mem_wdata = data_q[rd_ptr_q];
      end
      count_d = count_q + CW'(enq) - CW'(drain);
   end

   always_comb begin : occ_fsm
      state_d = state_q;
      case (state_q)
         S_EMPTY:   if (enq) state_d = S_PARTIAL;
         S_PARTIAL: begin
            if (count_d == CW'(DEPTH)) state_d = S_FULL;
            else if (count_d == '0)    state_d = S_EMPTY;
         end
         S_FULL:    if (count_d != CW'(DEPTH)) state_d = S_PARTIAL;
         default:   state_d = S_EMPTY;
      endcase
   end

   // Walk oldest to youngest so the last match is the youngest.
   always_comb begin : fwd
      logic [PW-1:0] idx;
      idx     = '0;
      ld_hit  = 1'b0;
      ld_data = '0;
      if (ld_valid) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (vld_q[idx] && (addr_q[idx] == ld_addr)) begin
               ld_hit  = 1'b1;
               ld_data = data_q[idx];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : regs
      if (!rst_n) begin
         state_q  <= S_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (drain) vld_q[rd_ptr_q] <= 1'b0;
         if (enq) begin
            vld_q[wr_ptr_q]  <= 1'b1;
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
         end
`ifdef STORE_BUF_COALESCE_EN
         if (st_valid && co_hit) data_q[yng_idx] <= st_data;
`endif
      end
   end

endmodule
